// File: rtl/calc_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
package calc_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] NEWLINE = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_NEXT = 2'd3
    } arb_state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first active requester at or after ptr wins.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            // One spare bit holds ptr+k before folding back into 0..N-1.
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates N_REQ byte-stream requesters onto one UART writer, locking the writer per message.
module tx_arbiter
    import calc_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic               tx_ready,
    output logic [7:0]         tx_data,
    input  logic               tx_rd,
    output logic [N_REQ-1:0]   grant,
    output logic               busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              last_q, last_d;
    logic              started_q, started_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  ptr_after;

    rr_picker #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req (req_vld),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign ptr_after = IDX_W'(wrap_inc(int'(owner_q), N_REQ));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        started_d = started_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        case (state_q)
            ST_IDLE: begin
                started_d = 1'b0;
                if (pick_any) begin
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (req_vld[owner_q]) begin
                    tx_data_d = req_data[BYTE_W*owner_q +: BYTE_W];
                    last_d    = req_last[owner_q];
                    ack_d     = grant_q;
                    started_d = 1'b1;
                    state_d   = ST_SEND;
                end else if (started_q) begin
                    cnt_d   = '0;
                    state_d = ST_NEXT;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_rd) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = ptr_after;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                // Mid-message gap: only the owner may continue; a stalled owner is dropped.
                if (req_vld[owner_q]) begin
                    state_d = ST_LOAD;
                end else if (cnt_q == CNT_END) begin
                    grant_d  = '0;
                    rr_ptr_d = ptr_after;
                    state_d  = ST_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tx_ready_d = (state_d == ST_SEND);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            last_q     <= 1'b0;
            started_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            started_q  <= started_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_ack  = ack_q;
    assign grant    = grant_q;
    assign tx_ready = tx_ready_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: requester/writer agents plus a message-level round-robin model.
module tb_tx_arbiter;
    import calc_pkg::*;

    localparam int N  = 2;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic           tx_ready;
    logic [7:0]     tx_data;
    logic           tx_rd;
    logic [N-1:0]   grant;
    logic           busy;

    tx_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_rd    (tx_rd),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } byte_t;

    typedef struct {
        int         owner;
        logic [7:0] data;
    } txb_t;

    byte_t rq [N][$];
    byte_t model_q [N][$];
    int    waited [N];
    int    ack_cnt [N];
    txb_t  exp_q [$];
    int    ready_lat [$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_rd     = 0;
    int rd_tick  = -100;
    int wr_delay = 3;
    int wr_wait  = 0;
    bit wr_en    = 1'b1;
    bit wr_rand  = 1'b0;

    logic         prev_ready = 1'b0;
    logic [7:0]   prev_data  = 8'h00;
    logic [N-1:0] prev_ack   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input logic l, input int g, input bit expect_tx);
        byte_t b;
        txb_t  e;
        b.data = d;
        b.last = l;
        b.gap  = g;
        rq[i].push_back(b);
        if (expect_tx) begin
            e.owner = i;
            e.data  = d;
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample DUT just after the edge, check invariants, then run the agents.
    task automatic tick();
        txb_t e;
        logic rd_edge;
        logic rst_edge;
        @(posedge clk);
        #1;
        cyc++;
        rd_edge  = tx_rd;
        rst_edge = rst;

        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check("ack_owner", 32'(req_ack & ~grant), 32'd0);
        check("ack_single", 32'(req_ack & prev_ack), 32'd0);
        if (prev_ready && rd_edge) check("ready_drop", 32'(tx_ready), 32'd0);
        if (prev_ready && !rd_edge && !rst_edge) begin
            check("ready_hold", 32'(tx_ready), 32'd1);
            check("data_hold", 32'(tx_data), 32'(prev_data));
        end
        if (tx_ready && !prev_ready) ready_lat.push_back(cyc - rd_tick);

        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                ack_cnt[i]++;
                check("ack_while_vld", 32'(req_vld[i]), 32'd1);
                if (req_vld[i] && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                    waited[i]  = 0;
                    req_vld[i] = 1'b0;
                end
            end
            if (!req_vld[i] && rq[i].size() > 0) begin
                if (waited[i] >= rq[i][0].gap) begin
                    req_vld[i]          = 1'b1;
                    req_data[8*i +: 8]  = rq[i][0].data;
                    req_last[i]         = rq[i][0].last;
                end else begin
                    waited[i]++;
                end
            end
        end

        if (tx_rd) begin
            tx_rd = 1'b0;
        end else if (wr_en && tx_ready) begin
            if (wr_wait >= wr_delay) begin
                tx_rd   = 1'b1;
                rd_tick = cyc;
                n_rd++;
                wr_wait = 0;
                if (wr_rand) wr_delay = $urandom_range(0, 4);
                check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("tx_owner", 32'(grant), 32'(1 << e.owner));
                end
            end else begin
                wr_wait++;
            end
        end

        prev_ready = tx_ready;
        prev_data  = tx_data;
        prev_ack   = req_ack;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || busy || tx_rd) && t < budget) begin
            tick();
            t++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_rd(input string tag, input int target, input int budget);
        int t = 0;
        while (n_rd < target && t < budget) begin
            tick();
            t++;
        end
        check(tag, 32'(n_rd >= target), 32'd1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            waited[i] = 0;
        end
        exp_q.delete();
        req_vld = '0;
        tx_rd   = 1'b0;
        wr_wait = 0;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int    t0;
        int    p;
        int    c;
        int    total;
        int    len;
        byte_t b;
        txb_t  e;

        rst      = 1'b1;
        req_vld  = '0;
        req_data = '0;
        req_last = '0;
        tx_rd    = 1'b0;
        for (int i = 0; i < N; i++) begin
            waited[i]  = 0;
            ack_cnt[i] = 0;
        end
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        tick();

        // Spurious tx_rd with nothing to send.
        tx_rd = 1'b1;
        tick();
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_ack", 32'(req_ack), 32'd0);
        tick();
        check("spur_busy2", 32'(busy), 32'd0);
        check("spur_grant", 32'(grant), 32'd0);

        // Single message "42\n" from requester 0, writer answers 3 cycles after tx_ready.
        wr_delay = 3;
        ready_lat.delete();
        push_byte(0, 8'h34, 1'b0, 0, 1'b1);
        push_byte(0, 8'h32, 1'b0, 0, 1'b1);
        push_byte(0, NEWLINE, 1'b1, 0, 1'b1);
        wait_idle("single", 200);
        check("single_acks", 32'(ack_cnt[0]), 32'd3);
        check("single_grant", 32'(grant), 32'd0);
        check("single_rises", 32'(ready_lat.size()), 32'd3);
        if (ready_lat.size() == 3) begin
            check("lat_byte2", 32'(ready_lat[1]), 32'd3);
            check("lat_byte3", 32'(ready_lat[2]), 32'd3);
        end

        // Contention from a fresh pointer: req0's message, then req1's, then req0 wins again.
        do_reset();
        wr_delay = 1;
        push_byte(0, 8'hA0, 1'b0, 0, 1'b1);
        push_byte(0, 8'hA1, 1'b1, 0, 1'b1);
        push_byte(1, 8'hB0, 1'b0, 0, 1'b1);
        push_byte(1, 8'hB1, 1'b1, 0, 1'b1);
        wait_idle("contend", 300);
        push_byte(0, 8'hC0, 1'b1, 0, 1'b1);
        push_byte(1, 8'hD0, 1'b1, 0, 1'b1);
        wait_idle("ptr_wrap", 200);

        // Lock: req1 arrives during req0's 5-cycle gap and must wait.
        wr_delay = 0;
        push_byte(0, 8'h51, 1'b0, 0, 1'b1);
        push_byte(0, 8'h52, 1'b1, 5, 1'b1);
        wait_rd("lock_first_rd", n_rd + 1, 100);
        push_byte(1, 8'h61, 1'b1, 0, 1'b1);
        tick();
        tick();
        check("lock_grant", 32'(grant), 32'd1);
        check("lock_busy", 32'(busy), 32'd1);
        check("lock_no_ack1", 32'(req_ack[1]), 32'd0);
        wait_idle("lock", 200);

        // Timeout: req0 stalls after one non-last byte; req1 takes over after 16 NEXT cycles.
        wr_delay = 0;
        push_byte(0, 8'h71, 1'b0, 0, 1'b1);
        wait_rd("to_first_rd", n_rd + 1, 100);
        t0 = rd_tick;
        push_byte(1, 8'h81, 1'b1, 0, 1'b1);
        while (cyc < t0 + 16) tick();
        check("to_grant_held", 32'(grant), 32'd1);
        tick();
        check("to_grant_clear", 32'(grant), 32'd0);
        check("to_busy_clear", 32'(busy), 32'd0);
        tick();
        check("to_grant_req1", 32'(grant), 32'd2);
        wait_idle("timeout", 100);

        // Reset while a byte is offered; the message is abandoned and a late tx_rd is ignored.
        wr_en = 1'b0;
        push_byte(0, 8'h91, 1'b0, 0, 1'b0);
        push_byte(0, 8'h92, 1'b1, 0, 1'b0);
        t0 = 0;
        while (!tx_ready && t0 < 50) begin
            tick();
            t0++;
        end
        check("mid_ready_seen", 32'(tx_ready), 32'd1);
        rst = 1'b1;
        rq[0].delete();
        req_vld = '0;
        tick();
        rst = 1'b0;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_ack", 32'(req_ack), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(tx_data), 32'd0);
        tx_rd = 1'b1;
        wr_en = 1'b1;
        tick();
        check("late_rd_busy", 32'(busy), 32'd0);
        check("late_rd_ack", 32'(req_ack), 32'd0);
        tick();
        check("late_rd_ready", 32'(tx_ready), 32'd0);
        check("late_rd_grant", 32'(grant), 32'd0);
        wr_delay = 2;
        push_byte(0, 8'hE1, 1'b0, 0, 1'b1);
        push_byte(0, 8'hE2, 1'b1, 0, 1'b1);
        wait_idle("rearb", 200);

        // Randomized traffic: both requesters queue several messages; order follows round-robin.
        do_reset();
        wr_rand  = 1'b1;
        wr_delay = $urandom_range(0, 4);
        total    = 0;
        for (int i = 0; i < N; i++) begin
            ack_cnt[i] = 0;
            model_q[i].delete();
            for (int m = 0; m < 6; m++) begin
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) begin
                    b.data = 8'($urandom_range(0, 255));
                    b.last = (j == len - 1);
                    b.gap  = (j == 0) ? 0 : $urandom_range(0, 6);
                    model_q[i].push_back(b);
                    push_byte(i, b.data, b.last, b.gap, 1'b0);
                    total++;
                end
            end
        end
        p = 0;
        while (model_q[0].size() + model_q[1].size() > 0) begin
            c = -1;
            for (int k = 0; k < N; k++) begin
                if (c < 0 && model_q[(p + k) % N].size() > 0) c = (p + k) % N;
            end
            do begin
                b       = model_q[c].pop_front();
                e.owner = c;
                e.data  = b.data;
                exp_q.push_back(e);
            end while (!b.last);
            p = (c + 1) % N;
        end
        wait_idle("random", 5000);
        check("random_acks", 32'(ack_cnt[0] + ack_cnt[1]), 32'(total));
        check("random_grant", 32'(grant), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
